// File: rtl/uart_boot_loader.sv
// UART boot loader: receives a length-prefixed little-endian word stream
// over 8N1 serial and writes it into instruction memory, then releases the CPU.
module uart_boot_loader #(
  parameter int          BUS_WIDTH    = 32,
  parameter int          CLKS_PER_BIT = 868,
  parameter int unsigned ADDR_BASE    = 0
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 rx,
  output logic                 iwr,
  output logic [BUS_WIDTH-1:0] iaddr,
  output logic [BUS_WIDTH-1:0] idata,
  output logic                 cpu_run,
  output logic                 busy,
  output logic                 done,
  output logic                 frame_err
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] C_FULL = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] C_HALF = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [BUS_WIDTH-1:0] A_BASE = BUS_WIDTH'(ADDR_BASE);
  localparam logic [BUS_WIDTH-1:0] A_STEP = BUS_WIDTH'(4);

  localparam logic [1:0] RX_IDLE  = 2'd0;
  localparam logic [1:0] RX_START = 2'd1;
  localparam logic [1:0] RX_DATA  = 2'd2;
  localparam logic [1:0] RX_STOP  = 2'd3;

  localparam logic [2:0] L_LEN0  = 3'd0;
  localparam logic [2:0] L_LEN1  = 3'd1;
  localparam logic [2:0] L_DATA  = 3'd2;
  localparam logic [2:0] L_WRITE = 3'd3;
  localparam logic [2:0] L_DONE  = 3'd4;
  localparam logic [2:0] L_ERR   = 3'd5;

  logic          r_sync1;
  logic          r_sync2;
  logic          r_rx_prev;
  logic [1:0]    r_rx_st;
  logic [CW-1:0] r_cnt;
  logic [2:0]    r_bit;
  logic [7:0]    r_shift;
  logic [7:0]    r_rx_byte;
  logic          r_byte_v;
  logic          r_ferr_p;
  logic          r_ferr;

  // Sync flops idle high so reset release never looks like a start bit.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_sync1   <= 1'b1;
      r_sync2   <= 1'b1;
      r_rx_prev <= 1'b1;
      r_rx_st   <= RX_IDLE;
      r_cnt     <= '0;
      r_bit     <= '0;
      r_shift   <= '0;
      r_rx_byte <= '0;
      r_byte_v  <= 1'b0;
      r_ferr_p  <= 1'b0;
      r_ferr    <= 1'b0;
    end else begin
      r_sync1   <= rx;
      r_sync2   <= r_sync1;
      r_rx_prev <= r_sync2;
      r_byte_v  <= 1'b0;
      r_ferr_p  <= 1'b0;
      case (r_rx_st)
        RX_IDLE: begin
          r_cnt <= '0;
          if (r_rx_prev && !r_sync2)
            r_rx_st <= RX_START;
        end
        RX_START: begin
          if (r_cnt == C_HALF) begin
            r_cnt   <= '0;
            r_bit   <= '0;
            r_rx_st <= r_sync2 ? RX_IDLE : RX_DATA;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        RX_DATA: begin
          if (r_cnt == C_FULL) begin
            r_cnt   <= '0;
            r_shift <= {r_sync2, r_shift[7:1]};
            r_bit   <= r_bit + 1'b1;
            if (r_bit == 3'd7)
              r_rx_st <= RX_STOP;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: begin
          if (r_cnt == C_FULL) begin
            r_cnt   <= '0;
            r_rx_st <= RX_IDLE;
            if (r_sync2) begin
              r_byte_v  <= 1'b1;
              r_rx_byte <= r_shift;
            end else begin
              r_ferr_p <= 1'b1;
              r_ferr   <= 1'b1;
            end
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
      endcase
    end
  end

  logic [2:0]           r_ld_st;
  logic [15:0]          r_len;
  logic [15:0]          r_k;
  logic [23:0]          r_word;
  logic [1:0]           r_bcnt;
  logic                 r_pend_v;
  logic [BUS_WIDTH-1:0] r_iaddr;
  logic [BUS_WIDTH-1:0] r_idata;
  logic                 w_bv;

  // A byte landing during WRITE is replayed from r_rx_byte in DATA.
  assign w_bv = r_byte_v | r_pend_v;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_ld_st  <= L_LEN0;
      r_len    <= '0;
      r_k      <= '0;
      r_word   <= '0;
      r_bcnt   <= '0;
      r_pend_v <= 1'b0;
      r_iaddr  <= A_BASE;
      r_idata  <= '0;
    end else if (r_ferr_p && r_ld_st != L_DONE) begin
      r_ld_st <= L_ERR;
    end else begin
      case (r_ld_st)
        L_LEN0: begin
          if (w_bv) begin
            r_len[7:0] <= r_rx_byte;
            r_ld_st    <= L_LEN1;
          end
        end
        L_LEN1: begin
          if (w_bv) begin
            r_len[15:8] <= r_rx_byte;
            if ({r_rx_byte, r_len[7:0]} == 16'd0)
              r_ld_st <= L_DONE;
            else
              r_ld_st <= L_DATA;
          end
        end
        L_DATA: begin
          if (w_bv) begin
            r_pend_v <= 1'b0;
            r_bcnt   <= r_bcnt + 1'b1;
            case (r_bcnt)
              2'd0: r_word[7:0]   <= r_rx_byte;
              2'd1: r_word[15:8]  <= r_rx_byte;
              2'd2: r_word[23:16] <= r_rx_byte;
              default: begin
                r_idata <= BUS_WIDTH'({r_rx_byte, r_word});
                r_iaddr <= (r_k == 16'd0) ? A_BASE : r_iaddr + A_STEP;
                r_ld_st <= L_WRITE;
              end
            endcase
          end
        end
        L_WRITE: begin
          r_k <= r_k + 16'd1;
          if (r_k + 16'd1 == r_len)
            r_ld_st <= L_DONE;
          else
            r_ld_st <= L_DATA;
          if (r_byte_v)
            r_pend_v <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign iwr       = (r_ld_st == L_WRITE);
  assign iaddr     = r_iaddr;
  assign idata     = r_idata;
  assign done      = (r_ld_st == L_DONE);
  assign cpu_run   = (r_ld_st == L_DONE);
  assign busy      = (r_ld_st == L_LEN1) ||
                     (r_ld_st == L_DATA) ||
                     (r_ld_st == L_WRITE);
  assign frame_err = r_ferr;

endmodule

// File: tb/tb_uart_boot_loader.sv
// Bench for uart_boot_loader: directed and random byte streams
// checked against a stream-level model of the expected writes.
module tb_uart_boot_loader;

  localparam int CPB = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        rx = 1'b1;
  logic        iwr;
  logic [31:0] iaddr;
  logic [31:0] idata;
  logic        cpu_run;
  logic        busy;
  logic        done;
  logic        frame_err;

  uart_boot_loader #(
    .BUS_WIDTH(32),
    .CLKS_PER_BIT(CPB),
    .ADDR_BASE(0)
  ) dut (
    .clk(clk),
    .reset(reset),
    .rx(rx),
    .iwr(iwr),
    .iaddr(iaddr),
    .idata(idata),
    .cpu_run(cpu_run),
    .busy(busy),
    .done(done),
    .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  logic [31:0] got_a[$];
  logic [31:0] got_d[$];
  int          rst_iwr = 0;

  logic [7:0]  sent_q[$];
  logic [31:0] exp_a[$];
  logic [31:0] exp_d[$];
  bit          m_err;
  bit          m_ferr;

  always @(negedge clk) begin
    if (iwr) begin
      if (!reset) rst_iwr++;
      got_a.push_back(iaddr);
      got_d.push_back(idata);
    end
  end

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic int model_len();
    if (sent_q.size() < 2) return -1;
    return int'(sent_q[0]) | (int'(sent_q[1]) << 8);
  endfunction

  function automatic bit model_done();
    int n;
    n = model_len();
    if (n < 0) return 1'b0;
    return sent_q.size() >= 2 + 4 * n;
  endfunction

  function automatic void model_writes();
    int n;
    exp_a.delete();
    exp_d.delete();
    n = model_len();
    for (int k = 0; k < n && 2 + 4 * k + 3 < sent_q.size(); k++) begin
      exp_a.push_back(32'(4 * k));
      exp_d.push_back({sent_q[2+4*k+3], sent_q[2+4*k+2],
                       sent_q[2+4*k+1], sent_q[2+4*k]});
    end
  endfunction

  task automatic send_raw(logic [7:0] b, bit stop_ok, int gap);
    @(negedge clk);
    rx = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (CPB) @(negedge clk);
    end
    rx = stop_ok;
    repeat (CPB) @(negedge clk);
    rx = 1'b1;
    repeat (2 + gap) @(negedge clk);
  endtask

  task automatic tx(logic [7:0] b, bit stop_ok, int gap);
    if (stop_ok) begin
      if (!m_err) sent_q.push_back(b);
    end else begin
      if (!model_done()) m_err = 1'b1;
      m_ferr = 1'b1;
    end
    send_raw(b, stop_ok, gap);
  endtask

  task automatic apply_reset(bit do_chk);
    @(negedge clk);
    reset = 1'b0;
    rx = 1'b1;
    #1;
    if (do_chk) begin
      chk("rst_iwr", 32'(iwr), 32'd0);
      chk("rst_iaddr", iaddr, 32'd0);
      chk("rst_idata", idata, 32'd0);
      chk("rst_cpu_run", 32'(cpu_run), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_ferr", 32'(frame_err), 32'd0);
    end
    repeat (3) @(negedge clk);
    got_a.delete();
    got_d.delete();
    sent_q.delete();
    m_err = 1'b0;
    m_ferr = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    if (do_chk) chk("rst_post_iwr", 32'(iwr), 32'd0);
  endtask

  task automatic check_result(string tag);
    bit edone;
    int nw;
    repeat (8) @(negedge clk);
    model_writes();
    edone = model_done() && !m_err;
    chk({tag, "_nwr"}, 32'(got_a.size()), 32'(exp_a.size()));
    nw = (got_a.size() < exp_a.size()) ? got_a.size() : exp_a.size();
    for (int i = 0; i < nw; i++) begin
      chk({tag, "_addr"}, got_a[i], exp_a[i]);
      chk({tag, "_data"}, got_d[i], exp_d[i]);
    end
    if (exp_a.size() > 0) begin
      chk({tag, "_hold_a"}, iaddr, exp_a[exp_a.size()-1]);
      chk({tag, "_hold_d"}, idata, exp_d[exp_d.size()-1]);
    end else begin
      chk({tag, "_hold_a"}, iaddr, 32'd0);
      chk({tag, "_hold_d"}, idata, 32'd0);
    end
    chk({tag, "_done"}, 32'(done), 32'(edone));
    chk({tag, "_run"}, 32'(cpu_run), 32'(edone));
    chk({tag, "_busy"}, 32'(busy),
        32'(!edone && !m_err && sent_q.size() > 0));
    chk({tag, "_ferr"}, 32'(frame_err), 32'(m_ferr));
  endtask

  initial begin
    logic [7:0] s033[10];
    logic [7:0] stream[$];
    int n;
    int epos;

    s033 = '{8'h02, 8'h00, 8'h13, 8'h00, 8'h00,
             8'h00, 8'hB7, 8'h10, 8'h00, 8'h00};

    repeat (2) @(negedge clk);
    chk("init_iwr", 32'(iwr), 32'd0);
    chk("init_iaddr", iaddr, 32'd0);
    chk("init_run", 32'(cpu_run), 32'd0);
    chk("init_ferr", 32'(frame_err), 32'd0);
    apply_reset(1'b0);

    // two-word program
    for (int i = 0; i < 10; i++) begin
      tx(s033[i], 1'b1, 1);
      if (i == 0) begin
        repeat (4) @(negedge clk);
        chk("d033_busy_mid", 32'(busy), 32'd1);
      end
    end
    check_result("d033");

    apply_reset(1'b1);
    tx(8'h00, 1'b1, 0);
    tx(8'h00, 1'b1, 0);
    check_result("d034");

    apply_reset(1'b0);
    tx(8'h01, 1'b0, 2);
    check_result("d035a");
    tx(8'h01, 1'b1, 0);
    tx(8'h00, 1'b1, 0);
    tx(8'h13, 1'b1, 0);
    tx(8'h00, 1'b1, 0);
    tx(8'h00, 1'b1, 0);
    tx(8'h00, 1'b1, 0);
    check_result("d035b");

    apply_reset(1'b0);
    @(negedge clk);
    rx = 1'b0;
    @(negedge clk);
    rx = 1'b1;
    repeat (20) @(negedge clk);
    check_result("d036a");
    tx(8'h00, 1'b1, 0);
    tx(8'h00, 1'b1, 0);
    check_result("d036b");

    apply_reset(1'b0);
    tx(8'h01, 1'b1, 0);
    tx(8'h00, 1'b1, 0);
    tx(8'hEF, 1'b1, 0);
    tx(8'hBE, 1'b1, 0);
    apply_reset(1'b1);
    chk("d037_rst_iwr", 32'(rst_iwr), 32'd0);
    tx(8'h01, 1'b1, 0);
    tx(8'h00, 1'b1, 0);
    tx(8'hEF, 1'b1, 0);
    tx(8'hBE, 1'b1, 0);
    tx(8'hAD, 1'b1, 0);
    tx(8'hDE, 1'b1, 3);
    check_result("d037");

    tx(8'hAA, 1'b1, 0);
    tx(8'h55, 1'b0, 0);
    tx(8'h12, 1'b1, 0);
    check_result("d038");

    for (int it = 0; it < 10; it++) begin
      apply_reset(1'b0);
      stream.delete();
      n = $urandom_range(0, 3);
      stream.push_back(8'(n));
      stream.push_back(8'h00);
      for (int j = 0; j < 4 * n; j++)
        stream.push_back(8'($urandom));
      epos = ($urandom_range(0, 2) == 0) ?
             $urandom_range(0, stream.size() - 1) : -1;
      for (int j = 0; j < stream.size(); j++)
        tx(stream[j], j != epos, $urandom_range(0, 6));
      if (epos >= 0) begin
        tx(8'h02, 1'b1, 0);
        tx(8'h00, 1'b1, 0);
      end
      check_result($sformatf("rnd%0d", it));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
